// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bundle for regfile_wb_arbiter: three write requesters, decode-stage
// hazard probes and the registered register-file write port.
interface regfile_wb_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             AluValid;
  logic [4:0]       AluAddr;
  logic [31:0]      AluData;
  logic             AluReady;
  logic             MemValid;
  logic [4:0]       MemAddr;
  logic [31:0]      MemData;
  logic             MemReady;
  logic             LinkValid;
  logic [31:0]      LinkData;
  logic             LinkReady;
  logic [4:0]       ReadAddr1;
  logic [4:0]       ReadAddr2;
  logic             RegWrite;
  logic [4:0]       WriteAddr;
  logic [31:0]      WBData;
  logic             Hazard1;
  logic             Hazard2;
  logic             Stall;
  logic [CNT_W-1:0] WriteCount;

  modport slave (
    input  AluValid, AluAddr, AluData, MemValid, MemAddr, MemData,
           LinkValid, LinkData, ReadAddr1, ReadAddr2,
    output AluReady, MemReady, LinkReady, RegWrite, WriteAddr, WBData,
           Hazard1, Hazard2, Stall, WriteCount
  );

  modport master (
    output AluValid, AluAddr, AluData, MemValid, MemAddr, MemData,
           LinkValid, LinkData, ReadAddr1, ReadAddr2,
    input  AluReady, MemReady, LinkReady, RegWrite, WriteAddr, WBData,
           Hazard1, Hazard2, Stall, WriteCount
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter merging ALU, load and link writebacks into one
// register-file write port, with per-requester single-entry buffers.
module regfile_wb_arbiter #(
  parameter int CNT_W = 16
) (
  input logic                   CLK,
  input logic                   Reset,
  regfile_wb_arbiter_if.slave   bus
);

  localparam logic [1:0] IDX_ALU  = 2'd0;
  localparam logic [1:0] IDX_MEM  = 2'd1;
  localparam logic [1:0] IDX_LINK = 2'd2;
  localparam logic [4:0] LINK_REG = 5'd31;

  logic [2:0]       r_valid;
  logic [4:0]       r_addr [3];
  logic [31:0]      r_data [3];
  logic [1:0]       r_last;
  logic             r_reg_write;
  logic [4:0]       r_write_addr;
  logic [31:0]      r_wb_data;
  logic [CNT_W-1:0] r_count;

  logic [2:0]  w_req_valid;
  logic [4:0]  w_req_addr [3];
  logic [31:0] w_req_data [3];
  logic [1:0]  w_s0, w_s1, w_s2;
  logic        w_gnt_any;
  logic [1:0]  w_gnt_idx;
  logic [2:0]  w_gnt;
  logic [2:0]  w_conf;
  logic [2:0]  w_ready;
  logic [2:0]  w_accept;
  logic        w_issue;
  logic        w_haz1, w_haz2;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    next_idx = (idx == IDX_LINK) ? IDX_ALU : idx + 2'd1;
  endfunction

  // Gather requester inputs into indexable form
  always_comb begin
    w_req_valid           = {bus.LinkValid, bus.MemValid, bus.AluValid};
    w_req_addr[IDX_ALU]   = bus.AluAddr;
    w_req_addr[IDX_MEM]   = bus.MemAddr;
    w_req_addr[IDX_LINK]  = LINK_REG;
    w_req_data[IDX_ALU]   = bus.AluData;
    w_req_data[IDX_MEM]   = bus.MemData;
    w_req_data[IDX_LINK]  = bus.LinkData;
  end

  // Round-robin grant starting one past the last granted buffer
  always_comb begin
    w_s0      = next_idx(r_last);
    w_s1      = next_idx(w_s0);
    w_s2      = next_idx(w_s1);
    w_gnt_any = 1'b1;
    if (r_valid[w_s0]) begin
      w_gnt_idx = w_s0;
    end else if (r_valid[w_s1]) begin
      w_gnt_idx = w_s1;
    end else if (r_valid[w_s2]) begin
      w_gnt_idx = w_s2;
    end else begin
      w_gnt_idx = IDX_ALU;
      w_gnt_any = 1'b0;
    end
    w_gnt = w_gnt_any ? (3'b001 << w_gnt_idx) : 3'b000;
    w_issue = w_gnt_any && (r_addr[w_gnt_idx] != 5'd0);
  end

  // An incoming address matching another occupied buffer must wait, so
  // same-register writes always retire in acceptance order.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_conf[i] = 1'b0;
      for (int j = 0; j < 3; j++) begin
        w_conf[i] = w_conf[i] |
                    ((i != j) && r_valid[j] && (r_addr[j] == w_req_addr[i]));
      end
      w_ready[i]  = !Reset && (!r_valid[i] || w_gnt[i]) && !w_conf[i];
      w_accept[i] = w_ready[i] && w_req_valid[i];
    end
  end

  // Pending-write hazard probes for the decode stage
  always_comb begin
    w_haz1 = (bus.ReadAddr1 != 5'd0) && r_reg_write && (r_write_addr == bus.ReadAddr1);
    w_haz2 = (bus.ReadAddr2 != 5'd0) && r_reg_write && (r_write_addr == bus.ReadAddr2);
    for (int i = 0; i < 3; i++) begin
      w_haz1 = w_haz1 | ((bus.ReadAddr1 != 5'd0) && r_valid[i] && (r_addr[i] == bus.ReadAddr1));
      w_haz2 = w_haz2 | ((bus.ReadAddr2 != 5'd0) && r_valid[i] && (r_addr[i] == bus.ReadAddr2));
    end
  end

  // Buffers, output stage, round-robin pointer and write counter
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_valid      <= 3'b000;
      r_last       <= IDX_LINK;
      r_reg_write  <= 1'b0;
      r_write_addr <= 5'd0;
      r_wb_data    <= 32'd0;
      r_count      <= '0;
      for (int i = 0; i < 3; i++) begin
        r_addr[i] <= 5'd0;
        r_data[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_accept[i]) begin
          r_valid[i] <= 1'b1;
          r_addr[i]  <= w_req_addr[i];
          r_data[i]  <= w_req_data[i];
        end else if (w_gnt[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
      r_reg_write <= w_issue;
      if (w_gnt_any) begin
        r_write_addr <= r_addr[w_gnt_idx];
        r_wb_data    <= r_data[w_gnt_idx];
        r_last       <= w_gnt_idx;
      end
      if (w_issue && (r_count != '1)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign bus.AluReady   = w_ready[IDX_ALU];
  assign bus.MemReady   = w_ready[IDX_MEM];
  assign bus.LinkReady  = w_ready[IDX_LINK];
  assign bus.RegWrite   = r_reg_write;
  assign bus.WriteAddr  = r_write_addr;
  assign bus.WBData     = r_wb_data;
  assign bus.Hazard1    = w_haz1;
  assign bus.Hazard2    = w_haz2;
  assign bus.Stall      = w_haz1 | w_haz2;
  assign bus.WriteCount = r_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a behavioural buffer model;
// a narrow counter is used so saturation is reached within the run.
module tb_regfile_wb_arbiter;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic CLK = 1'b0;
  logic Reset;
  int   n_vec = 0;
  int   n_err = 0;

  regfile_wb_arbiter_if #(.CNT_W(CW)) bus ();

  regfile_wb_arbiter #(.CNT_W(CW)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  // behavioural model state
  logic        mv [3];
  logic [4:0]  ma [3];
  logic [31:0] md [3];
  int          mlast;
  logic        mrw;
  logic [4:0]  mwa;
  logic [31:0] mwd;
  int          mcnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic pending(input logic [4:0] r);
    logic p;
    p = mrw && (mwa == r);
    for (int i = 0; i < 3; i++) p = p | (mv[i] && ma[i] == r);
    return (r != 5'd0) && p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mv[i] = 1'b0; ma[i] = 5'd0; md[i] = 32'd0;
    end
    mlast = 2; mrw = 1'b0; mwa = 5'd0; mwd = 32'd0; mcnt = 0;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic cycle();
    int          g;
    logic [2:0]  er;
    logic [2:0]  rv;
    logic [4:0]  ra [3];
    logic [31:0] rd [3];
    logic        conf, h1, h2;
    #1;
    rv = {bus.LinkValid, bus.MemValid, bus.AluValid};
    ra[0] = bus.AluAddr; ra[1] = bus.MemAddr; ra[2] = 5'd31;
    rd[0] = bus.AluData; rd[1] = bus.MemData; rd[2] = bus.LinkData;
    g = -1;
    for (int k = 1; k <= 3; k++) begin
      if (g < 0 && mv[(mlast + k) % 3]) g = (mlast + k) % 3;
    end
    for (int i = 0; i < 3; i++) begin
      conf = 1'b0;
      for (int j = 0; j < 3; j++)
        if (j != i && mv[j] && ma[j] == ra[i]) conf = 1'b1;
      er[i] = !Reset && (!mv[i] || g == i) && !conf;
    end
    h1 = pending(bus.ReadAddr1);
    h2 = pending(bus.ReadAddr2);
    check_eq("ready", {29'd0, bus.LinkReady, bus.MemReady, bus.AluReady}, {29'd0, er});
    check_eq("hazard", {29'd0, bus.Hazard1, bus.Hazard2, bus.Stall}, {29'd0, h1, h2, h1 | h2});
    check_eq("regwrite", {31'd0, bus.RegWrite}, {31'd0, mrw});
    check_eq("waddr", {27'd0, bus.WriteAddr}, {27'd0, mwa});
    check_eq("wbdata", bus.WBData, mwd);
    check_eq("wcount", {{(32-CW){1'b0}}, bus.WriteCount}, 32'(mcnt));
    @(posedge CLK);
    if (Reset) begin
      model_reset();
    end else begin
      mrw = 1'b0;
      if (g >= 0) begin
        mrw   = (ma[g] != 5'd0);
        mwa   = ma[g];
        mwd   = md[g];
        mlast = g;
        mv[g] = 1'b0;
        if (mrw && mcnt < CMAX) mcnt++;
      end
      for (int i = 0; i < 3; i++)
        if (rv[i] && er[i]) begin
          mv[i] = 1'b1; ma[i] = ra[i]; md[i] = rd[i];
        end
    end
    @(negedge CLK);
  endtask

  task automatic idle();
    bus.AluValid = 1'b0; bus.MemValid = 1'b0; bus.LinkValid = 1'b0;
    bus.ReadAddr1 = 5'd0; bus.ReadAddr2 = 5'd0; Reset = 1'b0;
  endtask

  function automatic logic [4:0] rand_addr();
    return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'(unsigned'($urandom_range(0, 7)));
  endfunction

  initial begin
    Reset = 1'b1;
    bus.AluAddr = 5'd0; bus.AluData = 32'd0; bus.MemAddr = 5'd0;
    bus.MemData = 32'd0; bus.LinkData = 32'd0;
    bus.AluValid = 1'b0; bus.MemValid = 1'b0; bus.LinkValid = 1'b0;
    bus.ReadAddr1 = 5'd0; bus.ReadAddr2 = 5'd0;
    repeat (2) @(posedge CLK);
    model_reset();
    @(negedge CLK);
    cycle();
    idle();
    cycle();

    // single ALU write, with hazard probe on its register
    bus.AluValid = 1'b1; bus.AluAddr = 5'd5; bus.AluData = 32'h1234;
    cycle();
    idle(); bus.ReadAddr1 = 5'd5;
    repeat (3) cycle();

    // three simultaneous requests
    bus.AluValid = 1'b1; bus.AluAddr = 5'd3; bus.AluData = 32'hA3;
    bus.MemValid = 1'b1; bus.MemAddr = 5'd4; bus.MemData = 32'hB4;
    bus.LinkValid = 1'b1; bus.LinkData = 32'hF0;
    cycle();
    idle(); bus.ReadAddr1 = 5'd31; bus.ReadAddr2 = 5'd4;
    repeat (4) cycle();

    // mem holds r31 while link requests r31
    bus.MemValid = 1'b1; bus.MemAddr = 5'd31; bus.MemData = 32'h55;
    cycle();
    idle(); bus.LinkValid = 1'b1; bus.LinkData = 32'h104;
    repeat (2) cycle();
    idle();
    repeat (3) cycle();

    // addr-0 write is consumed silently
    bus.AluValid = 1'b1; bus.AluAddr = 5'd0; bus.AluData = 32'hDEAD;
    cycle();
    idle();
    repeat (3) cycle();

    // reset with all buffers full
    bus.AluValid = 1'b1; bus.AluAddr = 5'd1; bus.MemValid = 1'b1; bus.MemAddr = 5'd2;
    bus.LinkValid = 1'b1;
    cycle();
    idle(); Reset = 1'b1;
    cycle();
    idle();
    repeat (3) cycle();

    // randomized traffic, long enough to saturate the counter
    for (int n = 0; n < 1500; n++) begin
      Reset         = ($urandom_range(0, 99) == 0);
      bus.AluValid  = 1'($urandom_range(0, 1));
      bus.AluAddr   = rand_addr();
      bus.AluData   = $urandom;
      bus.MemValid  = 1'($urandom_range(0, 1));
      bus.MemAddr   = rand_addr();
      bus.MemData   = $urandom;
      bus.LinkValid = ($urandom_range(0, 3) == 0);
      bus.LinkData  = $urandom;
      bus.ReadAddr1 = rand_addr();
      bus.ReadAddr2 = rand_addr();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the issued-write counter.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports AluValid input 1, AluAddr input 5, AluData input 32, AluReady output 1: requester 0 (ALU writeback).
REQ-005 SHALL have ports MemValid input 1, MemAddr input 5, MemData input 32, MemReady output 1: requester 1 (load writeback).
REQ-006 SHALL have ports LinkValid input 1, LinkData input 32 (pc+4), LinkReady output 1: requester 2; target fixed at register 31.
REQ-007 SHALL have ports ReadAddr1, ReadAddr2  input  5  decode-stage source registers for hazard check.
REQ-008 SHALL have ports RegWrite output 1, WriteAddr output 5, WBData output 32: registered register-file write port.
REQ-009 SHALL have ports Hazard1, Hazard2, Stall  output  1  combinational pending-write flags; Stall = Hazard1 | Hazard2.
REQ-010 SHALL have port WriteCount  output  CNT_W  number of RegWrite pulses issued.

Function
REQ-011 SHALL hold one single-entry buffer per requester (valid bit, 5-bit addr, 32-bit data).
REQ-012 SHALL accept requester i on a rising edge where Valid_i & Ready_i = 1, loading its buffer at that edge.
REQ-013 SHALL drive Ready_i = (buffer i empty | buffer i granted this cycle) & no address conflict.
REQ-014 SHALL flag address conflict for requester i when its address (31 for Link) equals the address of an occupied buffer j != i; Ready_i low that cycle.
REQ-015 SHALL, each cycle, grant exactly one occupied buffer (if any) round-robin: search starts at index (last granted + 1) mod 3.
REQ-016 SHALL on grant clear the granted buffer (unless refilled same edge per REQ-013) and load WriteAddr/WBData from it.
REQ-017 SHALL assert RegWrite for exactly one cycle after a grant edge when granted addr != 0; grant with addr 0 is consumed silently, RegWrite 0, counter unchanged.
REQ-018 SHALL hold RegWrite 0 in cycles with no grant; WriteAddr/WBData hold last value.
REQ-019 SHALL give minimum latency: accept at edge k, grant at edge k+1, RegWrite high in cycle between edges k+1 and k+2.
REQ-020 SHALL update the last-granted pointer only on grant cycles.
REQ-021 SHALL assert Hazard1 when ReadAddr1 != 0 and equals the addr of any occupied buffer or of the output stage while RegWrite = 1; Hazard2 likewise for ReadAddr2.
REQ-022 SHALL increment WriteCount on each RegWrite pulse, saturating at all-ones.
REQ-023 SHALL sustain one write per cycle when multiple buffers are occupied.
REQ-024 SHALL never issue two writes to the same address out of acceptance order (guaranteed by REQ-014).

Reset
REQ-025 SHALL, when Reset = 1 at a rising edge, clear all buffer valids, RegWrite, WriteAddr, WBData, WriteCount to 0 and set the last-granted pointer to 2 (priority order 0,1,2).
REQ-026 SHALL drop any in-flight buffered writes on mid-operation reset; no RegWrite in the cycle after the reset edge.
REQ-027 SHALL drive all Ready outputs 0 while Reset = 1.

Verification
REQ-028 Single ALU write: AluValid, AluAddr=5, AluData=0x1234 one cycle after reset -> RegWrite=1, WriteAddr=5, WBData=0x1234 two edges later, WriteCount=1.
REQ-029 Simultaneous Alu(addr 3), Mem(addr 4), Link(0xF0) after reset -> RegWrite pulses on three consecutive cycles in order 3, 4, 31; WriteCount=3.
REQ-030 Conflict: Mem buffer holds addr 31, LinkValid asserted -> LinkReady=0 until Mem granted; Link write issued next.
REQ-031 Hazard: ALU write addr 7 pending, ReadAddr1=7, ReadAddr2=0 -> Hazard1=1, Hazard2=0, Stall=1 until RegWrite cycle ends; ReadAddr=0 never flags.
REQ-032 Addr-0 write: AluAddr=0 accepted -> no RegWrite, WriteCount unchanged, AluReady returns 1.
REQ-033 Reset mid-operation with all three buffers full -> no RegWrite after reset, WriteCount=0, Ready outputs 1 in first non-reset cycle.
